// File: rtl/dmem_ctrl_pkg.sv
// Shared types and lane helpers for dmem_ctrl: access sizes, FSM states,
// sub-word extract/merge and the misalignment test.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RMW  = 2'b10
  } state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic r;
    case (size)
      SZ_BYTE: r = 1'b0;
      SZ_HALF: r = off[0];
      SZ_WORD: r = (off != 2'b00);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // Byte lane picked by off[1:0], half lane by off[1]; uns selects zero-extension.
  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: r = {{24{b[7] & ~uns}}, b};
      SZ_HALF: r = {{16{h[15] & ~uns}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [31:0] wdata,
                                             input logic [1:0] size, input logic [1:0] off);
    logic [31:0] r;
    r = word;
    case (size)
      SZ_BYTE: r[{off, 3'b000} +: 8]    = wdata[7:0];
      SZ_HALF: r[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: r = wdata;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// Two-requester round-robin arbiter (bit 0 = core, bit 1 = loader).
// The last-winner flop resets to "loader" so the core takes the first tie.
module dmem_rr_arb (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic r_last_ld;

  // Grant selection: a lone requester wins, a tie goes to whoever did not win last.
  always_comb begin
    o_gnt = 2'b00;
    if (i_req == 2'b11) begin
      o_gnt = r_last_ld ? 2'b01 : 2'b10;
    end else begin
      o_gnt = i_req;
    end
  end

  // Last-winner flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_ld <= 1'b1;
    end else if (o_gnt != 2'b00) begin
      r_last_ld <= o_gnt[1];
    end else begin
      r_last_ld <= r_last_ld;
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Load/store sequencer in front of the word-wide dmem: sub-word loads are
// extracted from the read word, sub-word stores become read-modify-write.
// Optional loader write port enabled by the macro DMEM_CTRL_LOADER_EN.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic [31:0]           i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_gnt,
  output logic                  o_done,
  output logic                  o_err,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
`ifdef DMEM_CTRL_LOADER_EN
  input  logic                  i_ld_req,
  input  logic [ADDR_WIDTH-1:0] i_ld_addr,
  input  logic [DATA_WIDTH-1:0] i_ld_wdata,
  output logic                  o_ld_gnt,
`endif
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  state_e                r_state;
  state_e                w_next_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [1:0]            r_off;
  logic [1:0]            r_size;
  logic                  r_uns;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_done;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_idle;
  logic                  w_core_win;
  logic                  w_ld_win;
  logic [ADDR_WIDTH-1:0] w_ld_addr;
  logic [DATA_WIDTH-1:0] w_ld_wdata;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic                  w_done_d;
  logic                  w_err_d;
  logic [DATA_WIDTH-1:0] w_rdata_d;
  logic                  w_unused_addr;

  assign w_idle        = (r_state == ST_IDLE);
  assign w_unused_addr = ^i_addr[31:ADDR_WIDTH+2];

`ifdef DMEM_CTRL_LOADER_EN
  logic [1:0] w_arb_gnt;

  dmem_rr_arb u_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req   ({i_ld_req & w_idle, i_req & w_idle}),
    .o_gnt   (w_arb_gnt)
  );

  assign w_core_win = w_arb_gnt[0];
  assign w_ld_win   = w_arb_gnt[1];
  assign w_ld_addr  = i_ld_addr;
  assign w_ld_wdata = i_ld_wdata;
  assign o_ld_gnt   = w_ld_win;
`else
  assign w_core_win = i_req & w_idle;
  assign w_ld_win   = 1'b0;
  assign w_ld_addr  = {ADDR_WIDTH{1'b0}};
  assign w_ld_wdata = {DATA_WIDTH{1'b0}};
`endif

  // Next state, memory port and completion values for the registered outputs.
  always_comb begin
    w_next_state = r_state;
    w_mem_we     = 1'b0;
    w_mem_addr   = i_addr[ADDR_WIDTH+1:2];
    w_mem_wdata  = i_wdata;
    w_done_d     = 1'b0;
    w_err_d      = 1'b0;
    w_rdata_d    = {DATA_WIDTH{1'b0}};
    case (r_state)
      ST_IDLE: begin
        if (w_core_win) begin
          if (is_misaligned(i_size, i_addr[1:0])) begin
            w_done_d = 1'b1;
            w_err_d  = 1'b1;
          end else if (i_we && (i_size == SZ_WORD)) begin
            w_mem_we = 1'b1;
            w_done_d = 1'b1;
          end else begin
            w_next_state = i_we ? ST_RMW : ST_LOAD;
          end
        end else if (w_ld_win) begin
          w_mem_we    = 1'b1;
          w_mem_addr  = w_ld_addr;
          w_mem_wdata = w_ld_wdata;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_LOAD: begin
        w_rdata_d    = lane_extract(i_mem_rdata, r_size, r_off, r_uns);
        w_done_d     = 1'b1;
        w_next_state = ST_IDLE;
      end
      ST_RMW: begin
        w_mem_we     = 1'b1;
        w_mem_addr   = r_addr;
        w_mem_wdata  = lane_merge(i_mem_rdata, r_wdata, r_size, r_off);
        w_done_d     = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Reset gates the write strobe so an abandoned RMW never reaches dmem.
  assign o_mem_we    = w_mem_we & i_rst_n;
  assign o_mem_addr  = w_mem_addr;
  assign o_mem_wdata = w_mem_wdata;
  assign o_gnt       = w_core_win;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_rdata     = r_rdata;

  // State and completion registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= {DATA_WIDTH{1'b0}};
    end else begin
      r_state <= w_next_state;
      r_done  <= w_done_d;
      r_err   <= w_err_d;
      r_rdata <= w_rdata_d;
    end
  end

  // Request capture at grant for the LOAD/RMW follow-up cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr  <= {ADDR_WIDTH{1'b0}};
      r_off   <= 2'b00;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_wdata <= {DATA_WIDTH{1'b0}};
    end else if (w_core_win) begin
      r_addr  <= i_addr[ADDR_WIDTH+1:2];
      r_off   <= i_addr[1:0];
      r_size  <= i_size;
      r_uns   <= i_unsigned;
      r_wdata <= i_wdata;
    end else begin
      r_addr  <= r_addr;
      r_off   <= r_off;
      r_size  <= r_size;
      r_uns   <= r_uns;
      r_wdata <= r_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a behavioural dmem and a completion scoreboard.
// Loader-port steps are compiled in when DMEM_CTRL_LOADER_EN is defined.
module tb_dmem_ctrl;

  localparam int AW = 9;

  logic          clk;
  logic          rst_n;
  logic          i_req, i_we, i_unsigned;
  logic [1:0]    i_size;
  logic [31:0]   i_addr, i_wdata;
  logic          o_gnt, o_done, o_err, o_mem_we;
  logic [31:0]   o_rdata, o_mem_wdata, mem_rdata;
  logic [AW-1:0] o_mem_addr;
`ifdef DMEM_CTRL_LOADER_EN
  logic          i_ld_req, o_ld_gnt;
  logic [AW-1:0] i_ld_addr;
  logic [31:0]   i_ld_wdata;
`endif

  logic [31:0] mem [0:(1<<AW)-1];
  logic [33:0] sb [$];   // {check_rdata, exp_err, exp_rdata}
  int checks = 0;
  int passed = 0;

  dmem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (i_req),
    .i_we        (i_we),
    .i_size      (i_size),
    .i_unsigned  (i_unsigned),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .o_gnt       (o_gnt),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_rdata     (o_rdata),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
`ifdef DMEM_CTRL_LOADER_EN
    .i_ld_req    (i_ld_req),
    .i_ld_addr   (i_ld_addr),
    .i_ld_wdata  (i_ld_wdata),
    .o_ld_gnt    (o_ld_gnt),
`endif
    .i_mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural dmem: one-cycle synchronous read, whole-word write.
  always @(posedge clk) begin
    mem_rdata <= mem[o_mem_addr];
    if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Completion scoreboard: pop on every o_done.
  always @(negedge clk) begin
    if (rst_n && o_done) begin
      chk("sb_pending", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        logic [33:0] e;
        e = sb.pop_front();
        chk("done_err", {31'd0, o_err}, {31'd0, e[32]});
        if (e[33]) chk("done_rdata", o_rdata, e[31:0]);
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic chk_rd, input logic exp_err, input logic [31:0] exp_rd);
    i_req = 1'b1; i_we = we; i_size = sz; i_unsigned = uns; i_addr = a; i_wdata = wd;
    sb.push_back({chk_rd, exp_err, exp_rd});
  endtask

  // Drop the request after the grant cycle and measure cycles to o_done.
  task automatic finish_op(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    @(posedge clk); #1;
    i_req = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (o_done) begin
        lat = k;
        break;
      end
    end
    chk(tag, lat, exp_lat);
  endtask

  task automatic op(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                    input logic [31:0] a, input logic [31:0] wd, input logic chk_rd,
                    input logic exp_err, input logic [31:0] exp_rd, input int exp_lat);
    @(posedge clk); #1;
    issue(we, sz, uns, a, wd, chk_rd, exp_err, exp_rd);
    @(negedge clk);
    chk({tag, "_gnt"}, {31'd0, o_gnt}, 32'd1);
    finish_op({tag, "_lat"}, exp_lat);
  endtask

  initial begin
    logic [31:0] keep0;
    rst_n = 1'b0; i_req = 1'b1; i_we = 1'b1; i_size = 2'b10; i_unsigned = 1'b0;
    i_addr = 32'h40; i_wdata = 32'hBAD0BAD0;
`ifdef DMEM_CTRL_LOADER_EN
    i_ld_req = 1'b0; i_ld_addr = '0; i_ld_wdata = 32'h0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_done",  {31'd0, o_done},   32'd0);
    chk("rst_err",   {31'd0, o_err},    32'd0);
    chk("rst_rdata", o_rdata,           32'd0);
    chk("rst_memwe", {31'd0, o_mem_we}, 32'd0);
    @(posedge clk); #1;
    i_req = 1'b0; rst_n = 1'b1;

    // Word store then sub-word loads.
    @(posedge clk); #1;
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("sw_gnt",   {31'd0, o_gnt},    32'd1);
    chk("sw_we",    {31'd0, o_mem_we}, 32'd1);
    chk("sw_addr",  {23'd0, o_mem_addr}, 32'd4);
    chk("sw_wdata", o_mem_wdata, 32'hDEADBEEF);
    finish_op("sw_lat", 1);
    op("lbu11", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b1, 1'b0, 32'h000000BE, 2);
    op("lb13",  1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b1, 1'b0, 32'hFFFFFFDE, 2);

    // Back-to-back word stores with the request held.
    @(posedge clk); #1;
    issue(1'b1, 2'b10, 1'b0, 32'h0, 32'h11111111, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("b2b0_gnt", {31'd0, o_gnt}, 32'd1);
    @(posedge clk); #1;
    issue(1'b1, 2'b10, 1'b0, 32'h4, 32'h22222222, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("b2b1_gnt",  {31'd0, o_gnt},  32'd1);
    chk("b2b1_done", {31'd0, o_done}, 32'd1);
    @(posedge clk); #1;
    issue(1'b1, 2'b10, 1'b0, 32'h8, 32'h33333333, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("b2b2_gnt",  {31'd0, o_gnt},  32'd1);
    chk("b2b2_done", {31'd0, o_done}, 32'd1);
    @(posedge clk); #1;
    i_req = 1'b0;
    @(negedge clk);
    chk("b2b3_done", {31'd0, o_done}, 32'd1);
    chk("b2b_mem0", mem[0], 32'h11111111);
    chk("b2b_mem1", mem[1], 32'h22222222);
    chk("b2b_mem2", mem[2], 32'h33333333);

    // Byte store as read-modify-write.
    @(posedge clk); #1;
    issue(1'b1, 2'b00, 1'b0, 32'h12, 32'h00000055, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("sb_gnt", {31'd0, o_gnt},    32'd1);
    chk("sb_c0we", {31'd0, o_mem_we}, 32'd0);
    @(posedge clk); #1;
    i_req = 1'b0;
    @(negedge clk);
    chk("sb_c1we",    {31'd0, o_mem_we}, 32'd1);
    chk("sb_c1addr",  {23'd0, o_mem_addr}, 32'd4);
    chk("sb_c1wdata", o_mem_wdata, 32'hDE55BEEF);
    chk("sb_c1done",  {31'd0, o_done}, 32'd0);
    @(negedge clk);
    chk("sb_c2done",  {31'd0, o_done}, 32'd1);
    op("lw10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'hDE55BEEF, 2);
    op("lhu12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b1, 1'b0, 32'h0000DE55, 2);
    op("lh12",  1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b1, 1'b0, 32'hFFFFDE55, 2);

    // Misaligned requests: error one cycle after grant, no memory access.
    keep0 = mem[0];
    @(posedge clk); #1;
    issue(1'b1, 2'b01, 1'b0, 32'h13, 32'h0000AAAA, 1'b1, 1'b1, 32'h0);
    @(negedge clk);
    chk("mis_sh_gnt", {31'd0, o_gnt},    32'd1);
    chk("mis_sh_we",  {31'd0, o_mem_we}, 32'd0);
    finish_op("mis_sh_lat", 1);
    op("mis_lw", 1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 1'b1, 1'b1, 32'h0, 1);
    op("ill_sz", 1'b1, 2'b11, 1'b0, 32'h00, 32'h0, 1'b1, 1'b1, 32'h0, 1);
    chk("mis_mem4", mem[4], 32'hDE55BEEF);
    chk("mis_mem0", mem[0], keep0);

    // Reset during the RMW cycle of a halfword store abandons the write.
    op("sw20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678, 1'b0, 1'b0, 32'h0, 1);
    @(posedge clk); #1;
    issue(1'b1, 2'b01, 1'b0, 32'h20, 32'h0000AAAA, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("shr_gnt", {31'd0, o_gnt}, 32'd1);
    @(posedge clk); #1;
    i_req = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("shr_we",    {31'd0, o_mem_we}, 32'd0);
    chk("shr_done",  {31'd0, o_done},   32'd0);
    chk("shr_err",   {31'd0, o_err},    32'd0);
    chk("shr_rdata", o_rdata,           32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("shr_mem8", mem[8], 32'h12345678);

`ifdef DMEM_CTRL_LOADER_EN
    // Ties alternate core, loader, core; a lone loader wins every cycle.
    @(posedge clk); #1;
    issue(1'b1, 2'b10, 1'b0, 32'h30, 32'hC0C0C0C0, 1'b0, 1'b0, 32'h0);
    i_ld_req = 1'b1; i_ld_addr = 9'd13; i_ld_wdata = 32'h1D1D1D1D;
    @(negedge clk);
    chk("tie0_gnt", {31'd0, o_gnt},    32'd1);
    chk("tie0_ld",  {31'd0, o_ld_gnt}, 32'd0);
    @(posedge clk); #1;
    issue(1'b1, 2'b10, 1'b0, 32'h38, 32'hC1C1C1C1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("tie1_gnt", {31'd0, o_gnt},    32'd0);
    chk("tie1_ld",  {31'd0, o_ld_gnt}, 32'd1);
    chk("tie1_addr", {23'd0, o_mem_addr}, 32'd13);
    @(posedge clk); #1;
    @(negedge clk);
    chk("tie2_gnt", {31'd0, o_gnt},    32'd1);
    chk("tie2_ld",  {31'd0, o_ld_gnt}, 32'd0);
    @(posedge clk); #1;
    i_req = 1'b0; i_ld_addr = 9'd15; i_ld_wdata = 32'h2F2F2F2F;
    @(negedge clk);
    chk("lone0_ld", {31'd0, o_ld_gnt}, 32'd1);
    @(posedge clk); #1;
    i_ld_addr = 9'd16; i_ld_wdata = 32'h30303030;
    @(negedge clk);
    chk("lone1_ld", {31'd0, o_ld_gnt}, 32'd1);
    @(posedge clk); #1;
    i_ld_req = 1'b0;
    @(negedge clk);
    chk("ld_mem12", mem[12], 32'hC0C0C0C0);
    chk("ld_mem13", mem[13], 32'h1D1D1D1D);
    chk("ld_mem14", mem[14], 32'hC1C1C1C1);
    chk("ld_mem15", mem[15], 32'h2F2F2F2F);
    chk("ld_mem16", mem[16], 32'h30303030);
`endif

    op("lw20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h12345678, 2);
    @(posedge clk); #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
